// File: rtl/branch_predictor_btb.sv
// branch_predictor_btb
// Branch target buffer with per-entry saturating direction counters.
//
// Ports:
//   clk, rst            clock; synchronous active-high reset
//   flush_all           pulse: invalidate every entry (starts a clear sweep)
//   lookup_valid/pc     fetch-side lookup, answered combinationally
//   predict_hit/taken/target
//                       lookup result; all zero on miss, when idle or while clearing
//   update_valid/pc/taken/target
//                       resolved branch from EX, at most one per cycle
//   init_busy           high while the clear sweep runs
//
// Address split: index = pc[IDX_W+1:2], tag = pc[IDX_W+2+TAG_W-1:IDX_W+2].
// Only the valid bits are ever cleared. Tag, target and counter storage has no
// reset, so it can map onto RAM.
//
// Optional macro BP_BYPASS_EN: when defined, a lookup that hits the index
// written by the same-cycle update sees the post-update entry (write-through).
// When undefined, the lookup sees the pre-update contents.
module branch_predictor_btb #(
  parameter int XLEN    = 32,
  parameter int ENTRIES = 64,
  parameter int TAG_W   = 8,
  parameter int CTR_W   = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush_all,
  input  logic            lookup_valid,
  input  logic [XLEN-1:0] lookup_pc,
  output logic            predict_hit,
  output logic            predict_taken,
  output logic [XLEN-1:0] predict_target,
  input  logic            update_valid,
  input  logic [XLEN-1:0] update_pc,
  input  logic            update_taken,
  input  logic [XLEN-1:0] update_target,
  output logic            init_busy
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_LO = IDX_W + 2;
  localparam int TAG_HI = IDX_W + 2 + TAG_W - 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ENTRIES - 1);
  localparam logic [CTR_W-1:0] CTR_MAX  = {CTR_W{1'b1}};
  localparam logic [CTR_W-1:0] CTR_MIN  = {CTR_W{1'b0}};
  localparam logic [CTR_W-1:0] CTR_WEAK = CTR_W'(1) << (CTR_W - 1);

  typedef enum logic {CLEAR = 1'b0, READY = 1'b1} state_t;

  state_t            state_r;
  logic [IDX_W-1:0]  clr_idx_r;
  logic [ENTRIES-1:0] valid_r;
  logic [TAG_W-1:0]  tag_mem_r    [ENTRIES];
  logic [XLEN-1:0]   target_mem_r [ENTRIES];
  logic [CTR_W-1:0]  ctr_mem_r    [ENTRIES];

  logic [IDX_W-1:0]  u_idx_s, l_idx_s;
  logic [TAG_W-1:0]  u_tag_s, l_tag_s;
  logic              upd_en_s, upd_hit_s, upd_write_s;
  logic [CTR_W-1:0]  new_ctr_s;
  logic [XLEN-1:0]   new_target_s;
  logic              e_valid_s;
  logic [TAG_W-1:0]  e_tag_s;
  logic [CTR_W-1:0]  e_ctr_s;
  logic [XLEN-1:0]   e_target_s;
  logic              hit_s;
  logic              unused_pc_bits_s;

  assign u_idx_s = update_pc[IDX_W+1:2];
  assign u_tag_s = update_pc[TAG_HI:TAG_LO];
  assign l_idx_s = lookup_pc[IDX_W+1:2];
  assign l_tag_s = lookup_pc[TAG_HI:TAG_LO];
  assign unused_pc_bits_s = ^{lookup_pc[1:0], lookup_pc[XLEN-1:TAG_HI+1],
                              update_pc[1:0], update_pc[XLEN-1:TAG_HI+1]};

  // An update is dropped while clearing, on a flush cycle and on a reset cycle.
  assign upd_en_s    = (state_r == READY) & update_valid & ~flush_all & ~rst;
  assign upd_hit_s   = valid_r[u_idx_s] & (tag_mem_r[u_idx_s] == u_tag_s);
  // A not-taken miss leaves the table untouched; everything else writes the entry.
  assign upd_write_s = upd_en_s & (upd_hit_s | update_taken);

  // Next counter/target for the entry addressed by the update port.
  always_comb begin
    new_ctr_s    = CTR_WEAK;
    new_target_s = update_target;
    if (upd_hit_s) begin
      if (update_taken) begin
        new_ctr_s    = (ctr_mem_r[u_idx_s] != CTR_MAX) ? ctr_mem_r[u_idx_s] + CTR_W'(1) : CTR_MAX;
        new_target_s = update_target;
      end else begin
        new_ctr_s    = (ctr_mem_r[u_idx_s] != CTR_MIN) ? ctr_mem_r[u_idx_s] - CTR_W'(1) : CTR_MIN;
        new_target_s = target_mem_r[u_idx_s];
      end
    end else begin
      new_ctr_s    = CTR_WEAK;
      new_target_s = update_target;
    end
  end

  // Select the entry seen by the lookup port (optionally the post-update one).
  always_comb begin
    e_valid_s  = valid_r[l_idx_s];
    e_tag_s    = tag_mem_r[l_idx_s];
    e_ctr_s    = ctr_mem_r[l_idx_s];
    e_target_s = target_mem_r[l_idx_s];
`ifdef BP_BYPASS_EN
    if (upd_write_s && (u_idx_s == l_idx_s)) begin
      e_valid_s  = 1'b1;
      e_tag_s    = u_tag_s;
      e_ctr_s    = new_ctr_s;
      e_target_s = new_target_s;
    end else begin
      e_valid_s  = valid_r[l_idx_s];
      e_tag_s    = tag_mem_r[l_idx_s];
      e_ctr_s    = ctr_mem_r[l_idx_s];
      e_target_s = target_mem_r[l_idx_s];
    end
`endif
  end

  assign hit_s          = lookup_valid & (state_r == READY) & e_valid_s & (e_tag_s == l_tag_s);
  assign predict_hit    = hit_s;
  assign predict_taken  = hit_s & e_ctr_s[CTR_W-1];
  assign predict_target = hit_s ? e_target_s : {XLEN{1'b0}};
  assign init_busy      = (state_r == CLEAR);

  // Sweep FSM and valid bits: clear one index per cycle, then accept updates.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= CLEAR;
      clr_idx_r <= {IDX_W{1'b0}};
    end else begin
      case (state_r)
        CLEAR: begin
          valid_r[clr_idx_r] <= 1'b0;
          if (flush_all) begin
            clr_idx_r <= {IDX_W{1'b0}};
          end else if (clr_idx_r == LAST_IDX) begin
            state_r <= READY;
          end else begin
            clr_idx_r <= clr_idx_r + IDX_W'(1);
          end
        end
        READY: begin
          if (flush_all) begin
            state_r   <= CLEAR;
            clr_idx_r <= {IDX_W{1'b0}};
          end else if (upd_write_s) begin
            valid_r[u_idx_s] <= 1'b1;
          end else begin
            state_r <= READY;
          end
        end
        default: begin
          state_r   <= CLEAR;
          clr_idx_r <= {IDX_W{1'b0}};
        end
      endcase
    end
  end

  // Entry payload: written on allocate or hit update, never reset.
  always_ff @(posedge clk) begin
    if (upd_write_s) begin
      tag_mem_r[u_idx_s]    <= u_tag_s;
      target_mem_r[u_idx_s] <= new_target_s;
      ctr_mem_r[u_idx_s]    <= new_ctr_s;
    end
  end

endmodule
